// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot and encoded grant.
// Optional hold timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt_onehot,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  if (PRIO_INIT >= N_REQ) begin : g_bad_prio_init
    $error("PRIO_INIT must be 0..7");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be 2..255");
  end

  // Returns {found, idx}: first set bit of r scanning upward from p, wrapping.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r,
                                          input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = p + IDX_W'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [N_REQ-1:0] gnt_onehot_q, gnt_onehot_d;

  logic             release_norm;
  logic             forced;
  logic             release_any;
  logic [IDX_W:0]   sel_idle;
  logic [IDX_W:0]   sel_rel;

  assign release_norm = done | ~req[gnt_idx_q];

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // Forced release only when no normal release happens in the same cycle.
  assign forced = (state_q == GRANT) & ~release_norm & (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d    = 8'd0;
    timeout_d = forced;
    if (state_q == GRANT && !release_any) hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_onehot_d = gnt_onehot_q;
    release_any  = 1'b0;
    sel_idle     = pick(req, ptr_q);
    sel_rel      = pick(req, gnt_idx_q + IDX_W'(1));
    case (state_q)
      IDLE: begin
        if (sel_idle[IDX_W]) begin
          state_d      = GRANT;
          gnt_idx_d    = sel_idle[IDX_W-1:0];
          gnt_valid_d  = 1'b1;
          gnt_onehot_d = N_REQ'(1) << sel_idle[IDX_W-1:0];
        end
      end
      GRANT: begin
        release_any = release_norm | forced;
        if (release_any) begin
          // Releasing holder is rescanned last, so it wins only if alone.
          ptr_d = gnt_idx_q + IDX_W'(1);
          if (sel_rel[IDX_W]) begin
            gnt_idx_d    = sel_rel[IDX_W-1:0];
            gnt_onehot_d = N_REQ'(1) << sel_rel[IDX_W-1:0];
          end else begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(PRIO_INIT);
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus randomized traffic against a reference model.
module tb_rr_arbiter_8;

  localparam int unsigned TB_MAX_HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_tmo;

  rr_arbiter_8 #(.PRIO_INIT(0), .MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_pick(input logic [7:0] r, input int p, output bit found, output int w);
    found = 1'b0;
    w = 0;
    for (int k = 0; k < 8; k++) begin
      if (!found && r[(p + k) % 8]) begin
        found = 1'b1;
        w = (p + k) % 8;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic check_model(input string ctx);
    logic [7:0] oh;
    oh = m_valid ? 8'(1 << m_idx) : 8'h00;
    check({ctx, ".valid"},   32'(gnt_valid),  32'(m_valid));
    check({ctx, ".idx"},     32'(gnt_idx),    32'(m_idx));
    check({ctx, ".onehot"},  32'(gnt_onehot), 32'(oh));
    check({ctx, ".timeout"}, 32'(timeout),    32'(m_tmo));
  endtask

  // Called at a negedge: apply inputs, advance model, clock, check at next negedge.
  task automatic step(input logic [7:0] r, input logic d, input string ctx);
    bit rel, forced, f;
    int w;
    req = r;
    done = d;
    m_tmo = 1'b0;
    if (!m_valid) begin
      if (r != 8'h00) begin
        model_pick(r, m_ptr, f, w);
        m_valid = 1'b1;
        m_idx = w;
        m_hold = 0;
      end
    end else begin
      rel = d || !r[m_idx];
      forced = TMO_EN && !rel && (m_hold == int'(TB_MAX_HOLD) - 1);
      if (rel || forced) begin
        m_ptr = (m_idx + 1) % 8;
        model_pick(r, m_ptr, f, w);
        if (f) m_idx = w;
        else m_valid = 1'b0;
        m_hold = 0;
      end else begin
        m_hold++;
      end
      m_tmo = forced;
    end
    @(posedge clk);
    @(negedge clk);
    check_model(ctx);
  endtask

  task automatic do_reset(input string ctx);
    #2 rst = 1'b1;
    #1;
    check({ctx, ".rst_valid"},   32'(gnt_valid),  32'd0);
    check({ctx, ".rst_idx"},     32'(gnt_idx),    32'd0);
    check({ctx, ".rst_onehot"},  32'(gnt_onehot), 32'd0);
    check({ctx, ".rst_timeout"}, 32'(timeout),    32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic       d;
    rst = 1'b1;
    req = 8'h00;
    done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // Single requester, then reset mid-grant
    step(8'h01, 1'b0, "req01");
    check("req01.idx", 32'(gnt_idx), 32'd0);
    check("req01.onehot", 32'(gnt_onehot), 32'h01);
    do_reset("midgrant");

    // Full request rotation with done pulses
    step(8'hFF, 1'b0, "ff_first");
    check("ff_first.idx", 32'(gnt_idx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 1'b1, "ff_rot");
      check("ff_rot.idx", 32'(gnt_idx), 32'((k + 1) % 8));
      check("ff_rot.valid", 32'(gnt_valid), 32'd1);
    end
    step(8'h00, 1'b1, "ff_drop");

    step(8'h90, 1'b0, "h90");
    check("h90.idx", 32'(gnt_idx), 32'd4);
    step(8'h90, 1'b1, "h90_done");
    check("h90_done.idx", 32'(gnt_idx), 32'd7);
    step(8'h10, 1'b1, "h10_done");
    check("h10_done.idx", 32'(gnt_idx), 32'd4);
    step(8'h00, 1'b1, "h00_done");
    check("h00_done.valid", 32'(gnt_valid), 32'd0);

    // Implicit release and no pre-emption
    step(8'h04, 1'b0, "idx2");
    check("idx2.idx", 32'(gnt_idx), 32'd2);
    step(8'h24, 1'b0, "nopreempt");
    check("nopreempt.idx", 32'(gnt_idx), 32'd2);
    step(8'h20, 1'b0, "implicit");
    check("implicit.idx", 32'(gnt_idx), 32'd5);
    check("implicit.onehot", 32'(gnt_onehot), 32'h20);

    // Sole holder re-granted
    step(8'h00, 1'b1, "to_idle");
    step(8'h40, 1'b0, "idx6");
    step(8'h40, 1'b1, "regrant6");
    check("regrant6.idx", 32'(gnt_idx), 32'd6);
    check("regrant6.valid", 32'(gnt_valid), 32'd1);

    // Hold timeout behaviour
    step(8'h00, 1'b1, "to_idle2");
    step(8'h03, 1'b0, "hold_start");
    check("hold_start.idx", 32'(gnt_idx), 32'd0);
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int k = 0; k < int'(TB_MAX_HOLD) - 1; k++) begin
      step(8'h03, 1'b0, "hold");
      check("hold.idx", 32'(gnt_idx), 32'd0);
    end
    step(8'h03, 1'b0, "forced");
    check("forced.idx", 32'(gnt_idx), 32'd1);
    check("forced.timeout", 32'(timeout), 32'd1);
    step(8'h03, 1'b0, "after_forced");
    check("after_forced.timeout", 32'(timeout), 32'd0);
`else
    for (int k = 0; k < 100; k++) begin
      step(8'h03, 1'b0, "hold");
      check("hold.idx", 32'(gnt_idx), 32'd0);
      check("hold.timeout", 32'(timeout), 32'd0);
    end
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand");
      end else begin
        r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        if (m_valid && $urandom_range(0, 1) == 1) r = r | 8'(1 << m_idx);
        d = ($urandom_range(0, 3) == 0);
        step(r, d, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
